// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter
//   Shares one single-ported framebuffer between the scanout engine (reads
//   only) and the blender (read-modify-write with a short address lock).
//
//   Ports
//     clk, reset          : rising-edge clock, synchronous active-low reset
//     so_req/so_addr      : scanout read request and pixel number
//     so_ack/so_rdata     : one-cycle done pulse and returned {r,g,b}
//     bl_req/bl_we/...    : blender request (we=0 read, we=1 write)
//     bl_ack/bl_rdata     : blender done pulse and read data
//     bl_abort            : pulse when the read lock expires without a write
//     mem_*               : framebuffer port; mem_req held until mem_ack
//     frame_ready         : blender end-of-frame strobe
//     o_frame_ready       : pulse once the frame is committed to memory
module fb_port_arbiter (
   input  logic        clk,
   input  logic        reset,
   input  logic        so_req,
   input  logic [18:0] so_addr,
   output logic        so_ack,
   output logic [23:0] so_rdata,
   input  logic        bl_req,
   input  logic        bl_we,
   input  logic [18:0] bl_addr,
   input  logic [23:0] bl_wdata,
   output logic        bl_ack,
   output logic [23:0] bl_rdata,
   output logic        bl_abort,
   output logic        mem_req,
   output logic        mem_we,
   output logic [18:0] mem_addr,
   output logic [23:0] mem_wdata,
   input  logic        mem_ack,
   input  logic [23:0] mem_rdata,
   input  logic        frame_ready,
   output logic        o_frame_ready
);

   typedef enum logic [2:0] {IDLE, SO_ACC, BL_RD, BL_HOLD, BL_WR} state_t;

   localparam logic [3:0] STARVE_MAX = 4'd8;
   localparam logic [2:0] HOLD_LAST  = 3'd3;  // count reaches 4 on this edge

   state_t      state_q;
   logic        mem_req_q, mem_we_q;
   logic [18:0] mem_addr_q;
   logic [23:0] mem_wdata_q;
   logic        so_ack_q, bl_ack_q, bl_abort_q, fr_out_q, fr_pend_q;
   logic [23:0] so_rdata_q, bl_rdata_q;
   logic [3:0]  starve_q;
   logic [2:0]  hold_q;

   logic bl_rd, starved, ack, wr_match;

   assign bl_rd    = bl_req & ~bl_we;
   assign starved  = (starve_q == STARVE_MAX) & bl_rd;
   // acks that arrive with no request outstanding are stray and dropped
   assign ack      = mem_ack & mem_req_q;
   // mem_addr_q still holds the locked read address while in BL_HOLD
   assign wr_match = bl_req & bl_we & (bl_addr == mem_addr_q);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         so_ack_q    <= 1'b0;
         bl_ack_q    <= 1'b0;
         bl_abort_q  <= 1'b0;
         fr_out_q    <= 1'b0;
         fr_pend_q   <= 1'b0;
         so_rdata_q  <= '0;
         bl_rdata_q  <= '0;
         starve_q    <= '0;
         hold_q      <= '0;
      end else begin
         so_ack_q   <= 1'b0;
         bl_ack_q   <= 1'b0;
         bl_abort_q <= 1'b0;
         fr_out_q   <= 1'b0;

         // Frame commit waits for IDLE so an open read lock or pending
         // write-back always lands before the frame is announced.
         if (fr_pend_q && state_q == IDLE) begin
            fr_out_q  <= 1'b1;
            fr_pend_q <= frame_ready;
         end else if (frame_ready) begin
            fr_pend_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (so_req && !starved) begin
                  state_q     <= SO_ACC;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= so_addr;
                  mem_wdata_q <= '0;
                  if (bl_rd && starve_q != STARVE_MAX)
                     starve_q <= starve_q + 4'd1;
               end else if (bl_rd) begin
                  state_q     <= BL_RD;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= bl_addr;
                  mem_wdata_q <= '0;
                  starve_q    <= '0;
               end
            end
            SO_ACC: begin
               if (ack) begin
                  mem_req_q  <= 1'b0;
                  so_ack_q   <= 1'b1;
                  so_rdata_q <= mem_rdata;
                  state_q    <= IDLE;
               end
            end
            BL_RD: begin
               if (ack) begin
                  mem_req_q  <= 1'b0;
                  bl_ack_q   <= 1'b1;
                  bl_rdata_q <= mem_rdata;
                  hold_q     <= '0;
                  state_q    <= BL_HOLD;
               end
            end
            BL_HOLD: begin
               if (wr_match) begin
                  state_q     <= BL_WR;
                  mem_req_q   <= 1'b1;
                  mem_we_q    <= 1'b1;
                  mem_wdata_q <= bl_wdata;
               end else if (hold_q == HOLD_LAST) begin
                  bl_abort_q <= 1'b1;
                  state_q    <= IDLE;
               end else begin
                  hold_q <= hold_q + 3'd1;
               end
            end
            BL_WR: begin
               if (ack) begin
                  mem_req_q <= 1'b0;
                  mem_we_q  <= 1'b0;
                  bl_ack_q  <= 1'b1;
                  state_q   <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign so_ack        = so_ack_q;
   assign so_rdata      = so_rdata_q;
   assign bl_ack        = bl_ack_q;
   assign bl_rdata      = bl_rdata_q;
   assign bl_abort      = bl_abort_q;
   assign mem_req       = mem_req_q;
   assign mem_we        = mem_we_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign o_frame_ready = fr_out_q;

endmodule

// File: tb/tb_fb_port_arbiter.sv
module tb_fb_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        so_req, bl_req, bl_we, frame_ready;
   logic [18:0] so_addr, bl_addr;
   logic [23:0] bl_wdata;
   logic        so_ack, bl_ack, bl_abort, o_frame_ready;
   logic [23:0] so_rdata, bl_rdata;
   logic        mem_req, mem_we, mem_ack;
   logic [18:0] mem_addr;
   logic [23:0] mem_wdata, mem_rdata;

   logic        rsp_ack = 1'b0, man_ack = 1'b0, auto_ack = 1'b1;
   logic [23:0] rsp_rdata = '0, man_rdata = '0;
   assign mem_ack   = rsp_ack | man_ack;
   assign mem_rdata = man_ack ? man_rdata : rsp_rdata;

   always #5 clk = ~clk;

   fb_port_arbiter dut (
      .clk(clk), .reset(reset),
      .so_req(so_req), .so_addr(so_addr), .so_ack(so_ack), .so_rdata(so_rdata),
      .bl_req(bl_req), .bl_we(bl_we), .bl_addr(bl_addr), .bl_wdata(bl_wdata),
      .bl_ack(bl_ack), .bl_rdata(bl_rdata), .bl_abort(bl_abort),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata),
      .frame_ready(frame_ready), .o_frame_ready(o_frame_ready)
   );

   int errs = 0;
   int chks = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0 ] exp);
      chks++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // framebuffer model; unwritten pixels read back as their own address
   logic [23:0] fb [int];
   function automatic logic [23:0] fb_rd(input logic [18:0] a);
      if (fb.exists(int'(a))) return fb[int'(a)];
      return {5'd0, a};
   endfunction

   // memory responder: acks one cycle after mem_req is first seen
   int cyc = 0;
   always @(negedge clk) begin
      if (!auto_ack) begin
         rsp_ack = 1'b0;
         cyc = 0;
      end else if (rsp_ack) begin
         rsp_ack = 1'b0;
         cyc = 0;
      end else if (mem_req) begin
         cyc++;
         if (cyc > 1) begin
            rsp_ack   = 1'b1;
            rsp_rdata = fb_rd(mem_addr);
            if (mem_we) fb[int'(mem_addr)] = mem_wdata;
         end
      end else begin
         cyc = 0;
      end
   end

   // scoreboard
   typedef struct { bit rd; logic [23:0] d; } bl_exp_t;
   logic [23:0] so_exp [$];
   bl_exp_t     bl_exp [$];

   always @(negedge clk) begin
      logic [23:0] se;
      bl_exp_t     be;
      if (so_ack) begin
         chk("so_ack_expected", so_exp.size() > 0, 1'b1);
         if (so_exp.size() > 0) begin
            se = so_exp.pop_front();
            chk("so_rdata", so_rdata, se);
         end
      end
      if (bl_ack) begin
         chk("bl_ack_expected", bl_exp.size() > 0, 1'b1);
         if (bl_exp.size() > 0) begin
            be = bl_exp.pop_front();
            if (be.rd) chk("bl_rdata", bl_rdata, be.d);
         end
      end
      if (so_ack || bl_ack || bl_abort)
         chk("ack_exclusive", 32'(so_ack) + 32'(bl_ack) + 32'(bl_abort), 1);
   end

   int n, got, seen, cnt, early;

   initial begin
      reset = 1'b0; so_req = 0; so_addr = '0; bl_req = 0; bl_we = 0;
      bl_addr = '0; bl_wdata = '0; frame_ready = 0;
      fb[1234] = 24'h804080; fb[5] = 24'h010203; fb[7] = 24'h070707;
      fb[9] = 24'hABCDEF; fb[11] = 24'h112233;
      repeat (3) @(negedge clk);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_so_ack", so_ack, 0);
      chk("rst_bl_ack", bl_ack, 0);
      chk("rst_bl_abort", bl_abort, 0);
      chk("rst_frame", o_frame_ready, 0);
      chk("rst_so_rdata", so_rdata, 0);
      chk("rst_bl_rdata", bl_rdata, 0);
      reset = 1'b1;
      @(negedge clk);

      // scanout read, minimum latency
      so_req = 1; so_addr = 19'd1234; so_exp.push_back(24'h804080);
      n = 0; got = 0; seen = 0;
      while (!got && n < 20) begin
         @(negedge clk); n++;
         if (mem_req && !seen) begin
            seen = 1;
            chk("so_mem_addr", mem_addr, 1234);
            chk("so_mem_we", mem_we, 0);
         end
         if (so_ack) got = 1;
      end
      so_req = 0;
      chk("so_ack_seen", got, 1);
      chk("so_latency", n, 3);
      @(negedge clk);
      chk("so_ack_pulse", so_ack, 0);
      chk("so_no_regrant", mem_req, 0);

      // blender read-modify-write with scanout waiting
      bl_req = 1; bl_we = 0; bl_addr = 19'd5; bl_exp.push_back('{1'b1, 24'h010203});
      n = 0; got = 0;
      while (!got && n < 20) begin @(negedge clk); n++; if (bl_ack) got = 1; end
      chk("rmw_rd_ack", got, 1);
      bl_we = 1; bl_wdata = 24'h09060F; bl_exp.push_back('{1'b0, 24'h0});
      so_req = 1; so_addr = 19'd100; so_exp.push_back(24'h000064);
      n = 0; got = 0; seen = 0; cnt = 0;
      while (!got && n < 20) begin
         @(negedge clk); n++;
         if (mem_req && !seen) begin
            seen = 1;
            chk("rmw_wr_we", mem_we, 1);
            chk("rmw_wr_addr", mem_addr, 5);
            chk("rmw_wr_data", mem_wdata, 24'h09060F);
         end
         if (so_ack) cnt++;
         if (bl_ack) got = 1;
      end
      bl_req = 0; bl_we = 0;
      chk("rmw_wr_ack", got, 1);
      chk("rmw_no_so_between", cnt, 0);
      n = 0; got = 0;
      while (!got && n < 20) begin @(negedge clk); n++; if (so_ack) got = 1; end
      so_req = 0;
      chk("rmw_so_after", got, 1);

      // lock timeout, mismatched write address must not be granted
      bl_req = 1; bl_we = 0; bl_addr = 19'd7; bl_exp.push_back('{1'b1, 24'h070707});
      n = 0; got = 0;
      while (!got && n < 20) begin @(negedge clk); n++; if (bl_ack) got = 1; end
      chk("to_rd_ack", got, 1);
      bl_we = 1; bl_addr = 19'd8; bl_wdata = 24'hFFFFFF;
      so_req = 1; so_addr = 19'd20; so_exp.push_back(24'h000014);
      n = 0; got = 0; cnt = 0;
      while (!got && n < 20) begin
         @(negedge clk); n++;
         if (mem_req) cnt++;
         if (bl_abort) got = 1;
      end
      bl_req = 0; bl_we = 0;
      chk("to_abort_seen", got, 1);
      chk("to_abort_cycles", n, 4);
      chk("to_no_grant_in_hold", cnt, 0);
      @(negedge clk);
      chk("to_abort_pulse", bl_abort, 0);
      chk("to_so_granted", mem_req, 1);
      chk("to_so_addr", mem_addr, 20);
      n = 0; got = 0;
      while (!got && n < 20) begin @(negedge clk); n++; if (so_ack) got = 1; end
      so_req = 0;
      chk("to_so_ack", got, 1);

      // starvation: scanout held, blender gets in after 8 scanout accesses
      for (int i = 0; i < 8; i++) so_exp.push_back(24'h00001E);
      bl_exp.push_back('{1'b1, 24'hABCDEF});
      so_req = 1; so_addr = 19'd30; bl_req = 1; bl_we = 0; bl_addr = 19'd9;
      n = 0; got = 0; cnt = 0;
      while (!got && n < 200) begin
         @(negedge clk); n++;
         if (so_ack) cnt++;
         if (bl_ack) got = 1;
      end
      so_req = 0; bl_req = 0;
      chk("starve_bl_granted", got, 1);
      chk("starve_so_count", cnt, 8);
      n = 0; got = 0;
      while (!got && n < 20) begin @(negedge clk); n++; if (bl_abort) got = 1; end
      chk("starve_abort", got, 1);

      // frame_ready in IDLE
      @(negedge clk);
      frame_ready = 1;
      @(negedge clk); frame_ready = 0;
      chk("fr_idle_wait", o_frame_ready, 0);
      @(negedge clk); chk("fr_idle_pulse", o_frame_ready, 1);
      @(negedge clk); chk("fr_idle_once", o_frame_ready, 0);

      // frame_ready during the lock is held back until the write-back
      bl_req = 1; bl_we = 0; bl_addr = 19'd11; bl_exp.push_back('{1'b1, 24'h112233});
      n = 0; got = 0;
      while (!got && n < 20) begin @(negedge clk); n++; if (bl_ack) got = 1; end
      chk("fr_rd_ack", got, 1);
      frame_ready = 1; bl_req = 0;
      @(negedge clk);
      early = 32'(o_frame_ready);
      frame_ready = 0; bl_req = 1; bl_we = 1; bl_wdata = 24'h445566;
      bl_exp.push_back('{1'b0, 24'h0});
      n = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge clk); n++;
         if (o_frame_ready) early++;
         if (bl_ack) got = 1;
      end
      bl_req = 0; bl_we = 0;
      chk("fr_wr_ack", got, 1);
      chk("fr_not_early", early, 0);
      @(negedge clk); chk("fr_after_wr", o_frame_ready, 1);
      @(negedge clk); chk("fr_after_once", o_frame_ready, 0);

      // reset in the middle of a scanout access, then a stray mem_ack
      auto_ack = 0;
      so_req = 1; so_addr = 19'd40;
      n = 0; got = 0;
      while (!got && n < 20) begin @(negedge clk); n++; if (mem_req) got = 1; end
      chk("rst_acc_started", got, 1);
      reset = 0; so_req = 0;
      @(negedge clk);
      chk("rst_mid_mem_req", mem_req, 0);
      chk("rst_mid_so_ack", so_ack, 0);
      reset = 1; man_ack = 1; man_rdata = 24'h123456;
      @(negedge clk);
      man_ack = 0;
      chk("rst_stray_so_ack", so_ack, 0);
      @(negedge clk);
      chk("rst_stray_mem_req", mem_req, 0);
      chk("rst_stray_so_ack2", so_ack, 0);
      chk("rst_stray_so_rdata", so_rdata, 0);

      // recovery
      auto_ack = 1;
      so_req = 1; so_addr = 19'd1234; so_exp.push_back(24'h804080);
      n = 0; got = 0;
      while (!got && n < 20) begin @(negedge clk); n++; if (so_ack) got = 1; end
      so_req = 0;
      chk("recover_so_ack", got, 1);

      @(negedge clk);
      chk("so_sb_empty", so_exp.size(), 0);
      chk("bl_sb_empty", bl_exp.size(), 0);
      $display("Result: errors=%0d of %0d checks", errs, chks);
      $finish;
   end

endmodule
